wb_broadcaster: RTL

Writeback broadcaster for the out-of-order core: collects completed results from the ALU and load/store units, buffers them in two per-source FIFOs, and drives the two result broadcast channels (O and T) consumed by the register file, reservation stations and ROB. It is the producing end of the `enWrtO/WrtTagO/WrtDataO` and `enWrtT/WrtTagT/WrtDataT` writeback buses. It never drops a valid result and provides two broadcasts per cycle regardless of source mix.

---
 rtl/wb_broadcaster.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/wb_broadcaster.sv
// Writeback broadcaster: buffers ALU and LS results in two FIFOs
// and drives the O and T result broadcast channels.
module wb_broadcaster #(
  parameter int TAG_W = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter logic [TAG_W-1:0] TAG_FREE = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              misTaken,
  input  logic              aluEn,
  input  logic [TAG_W-1:0]  aluTag,
  input  logic [DATA_W-1:0] aluData,
  output logic              aluRdy,
  input  logic              lsEn,
  input  logic [TAG_W-1:0]  lsTag,
  input  logic [DATA_W-1:0] lsData,
  output logic              lsRdy,
  output logic              enWrtO,
  output logic [TAG_W-1:0]  WrtTagO,
  output logic [DATA_W-1:0] WrtDataO,
  output logic              enWrtT,
  output logic [TAG_W-1:0]  WrtTagT,
  output logic [DATA_W-1:0] WrtDataT
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [TAG_W-1:0]  tagA [DEPTH];
  logic [DATA_W-1:0] datA [DEPTH];
  logic [TAG_W-1:0]  tagL [DEPTH];
  logic [DATA_W-1:0] datL [DEPTH];

  logic [PW-1:0] headA, tailA, headL, tailL;
  logic [PW-1:0] headA1, headL1;
  logic [CW-1:0] cntA, cntL;

  logic          hasA, hasL;
  logic          storeA, storeL;
  logic [1:0]    popA, popL;

  logic              nEnO, nEnT;
  logic [TAG_W-1:0]  nTagO, nTagT;
  logic [DATA_W-1:0] nDatO, nDatT;

  assign aluRdy = rdy & (cntA != FULL);
  assign lsRdy  = rdy & (cntL != FULL);

  assign storeA = aluEn & aluRdy & ~misTaken
                & (aluTag != TAG_FREE);
  assign storeL = lsEn & lsRdy & ~misTaken
                & (lsTag != TAG_FREE);

  assign hasA   = cntA != '0;
  assign hasL   = cntL != '0;
  assign headA1 = headA + 1'b1;
  assign headL1 = headL + 1'b1;

  // choose what goes on O and T from the pre-edge FIFO state
  always_comb begin
    popA  = 2'd0;
    popL  = 2'd0;
    nEnO  = 1'b0;
    nTagO = TAG_FREE;
    nDatO = '0;
    nEnT  = 1'b0;
    nTagT = TAG_FREE;
    nDatT = '0;
    unique case (1'b1)
      hasA && hasL: begin
        popA  = 2'd1;
        popL  = 2'd1;
        nEnO  = 1'b1;
        nTagO = tagA[headA];
        nDatO = datA[headA];
        nEnT  = 1'b1;
        nTagT = tagL[headL];
        nDatT = datL[headL];
      end
      (cntA > CW'(1)) && !hasL: begin
        popA  = 2'd2;
        nEnO  = 1'b1;
        nTagO = tagA[headA];
        nDatO = datA[headA];
        nEnT  = 1'b1;
        nTagT = tagA[headA1];
        nDatT = datA[headA1];
      end
      (cntL > CW'(1)) && !hasA: begin
        popL  = 2'd2;
        nEnO  = 1'b1;
        nTagO = tagL[headL];
        nDatO = datL[headL];
        nEnT  = 1'b1;
        nTagT = tagL[headL1];
        nDatT = datL[headL1];
      end
      (cntA == CW'(1)) && !hasL: begin
        popA  = 2'd1;
        nEnO  = 1'b1;
        nTagO = tagA[headA];
        nDatO = datA[headA];
      end
      (cntL == CW'(1)) && !hasA: begin
        popL  = 2'd1;
        nEnO  = 1'b1;
        nTagO = tagL[headL];
        nDatO = datL[headL];
      end
      !hasA && !hasL: begin
        popA = 2'd0;
      end
    endcase
  end

  // FIFO storage; slots need no reset since counts gate reads
  always_ff @(posedge clk) begin
    if (storeA) begin
      tagA[tailA] <= aluTag;
      datA[tailA] <= aluData;
    end
    if (storeL) begin
      tagL[tailL] <= lsTag;
      datL[tailL] <= lsData;
    end
  end

  // pointers, counts and registered broadcast outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      headA    <= '0;
      tailA    <= '0;
      cntA     <= '0;
      headL    <= '0;
      tailL    <= '0;
      cntL     <= '0;
      enWrtO   <= 1'b0;
      WrtTagO  <= TAG_FREE;
      WrtDataO <= '0;
      enWrtT   <= 1'b0;
      WrtTagT  <= TAG_FREE;
      WrtDataT <= '0;
    end else if (rdy) begin
      if (misTaken) begin
        headA    <= '0;
        tailA    <= '0;
        cntA     <= '0;
        headL    <= '0;
        tailL    <= '0;
        cntL     <= '0;
        enWrtO   <= 1'b0;
        WrtTagO  <= TAG_FREE;
        WrtDataO <= '0;
        enWrtT   <= 1'b0;
        WrtTagT  <= TAG_FREE;
        WrtDataT <= '0;
      end else begin
        headA    <= headA + PW'(popA);
        headL    <= headL + PW'(popL);
        tailA    <= tailA + PW'(storeA);
        tailL    <= tailL + PW'(storeL);
        cntA     <= cntA - CW'(popA) + CW'(storeA);
        cntL     <= cntL - CW'(popL) + CW'(storeL);
        enWrtO   <= nEnO;
        WrtTagO  <= nTagO;
        WrtDataO <= nDatO;
        enWrtT   <= nEnT;
        WrtTagT  <= nTagT;
        WrtDataT <= nDatT;
      end
    end
  end

endmodule
